// File: rtl/stream_arbiter.sv
// Round-robin arbiter sharing one stb/ack consumer among N stb/ack producers.
// One word per grant, re-offered downstream tagged with its source channel.
module stream_arbiter #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_stb,
  output logic [N-1:0]       in_ack,
  output logic [WIDTH-1:0]   out_data,
  output logic [ID_W-1:0]    out_id,
  output logic               out_stb,
  input  logic               out_ack,
  output logic               busy
);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("stream_arbiter: N must be 2..8");
  end
  if ((2 ** ID_W) < N) begin : g_bad_id
    $error("stream_arbiter: ID_W too narrow for N");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    OFFER
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   g_q, g_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [N-1:0]      in_ack_q, in_ack_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic              out_stb_q, out_stb_d;
  logic              busy_q, busy_d;

  logic [2*N-1:0]    rot;
  logic [N-1:0]      rot_n;
  logic [ID_W-1:0]   pick;
  logic [N-1:0]      pick_oh;
  logic [WIDTH-1:0]  slice;
  int                off;
  int                s;

  // Rotate requests so bit 0 is the channel right after the last grant.
  always_comb begin
    rot   = {in_stb, in_stb} >> (int'(last_q) + 1);
    rot_n = rot[N-1:0];
    off   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot_n[i]) off = i;
    end
    s = int'(last_q) + 1 + off;
    if (s >= N) s = s - N;
    pick = ID_W'(s);
    pick_oh = '0;
    for (int k = 0; k < N; k++) begin
      pick_oh[k] = (pick == ID_W'(k));
    end
  end

  always_comb begin
    slice = '0;
    for (int k = 0; k < N; k++) begin
      if (g_q == ID_W'(k)) slice = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    last_d     = last_q;
    in_ack_d   = in_ack_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    out_stb_d  = out_stb_q;
    unique case (state_q)
      IDLE: begin
        if (|in_stb) begin
          g_d      = pick;
          in_ack_d = pick_oh;
          state_d  = ACCEPT;
        end
      end
      ACCEPT: begin
        // in_ack_q is one-hot on g, so this is in_stb[g].
        if (|(in_stb & in_ack_q)) begin
          out_data_d = slice;
          out_id_d   = g_q;
          out_stb_d  = 1'b1;
          in_ack_d   = '0;
          state_d    = OFFER;
        end
      end
      OFFER: begin
        if (out_ack) begin
          out_stb_d = 1'b0;
          last_d    = g_q;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        in_ack_d  = '0;
        out_stb_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      g_q        <= '0;
      last_q     <= ID_W'(N - 1);
      in_ack_q   <= '0;
      out_data_q <= '0;
      out_id_q   <= '0;
      out_stb_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      last_q     <= last_d;
      in_ack_q   <= in_ack_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      out_stb_q  <= out_stb_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ack   = in_ack_q;
  assign out_data = out_data_q;
  assign out_id   = out_id_q;
  assign out_stb  = out_stb_q;
  assign busy     = busy_q;

endmodule

// File: doc/stream_arbiter.md
Name: stream_arbiter

Overview:
Round-robin arbiter that shares a single stb/ack stream consumer (file_writer, FPU operand port) among N stb/ack producers (file_readers, FPU result streams).
It accepts one word per grant from the selected requester and re-offers it downstream with the source channel id.
Grants rotate so no requester starves.
It sits between test-harness/C2CHIP-generated processes and any shared single-input sink.

Parameters:
WIDTH, 16, data width of every stream
N, 4, number of requesters (2..8)
ID_W, 2, width of channel id; must satisfy 2**ID_W >= N

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_data  input  N*WIDTH  requester data, channel k at bits [k*WIDTH+WIDTH-1 : k*WIDTH]
in_stb  input  N  requester strobe, one bit per channel
in_ack  output  N  requester acknowledge, one bit per channel
out_data  output  WIDTH  word offered to consumer
out_id  output  ID_W  channel that produced out_data
out_stb  output  1  word valid toward consumer
out_ack  input  1  consumer acknowledge
busy  output  1  high whenever state is not IDLE

Behaviour:
- Handshake, both sides:
  - A transfer occurs on a rising edge where stb and ack are both high.
  - A producer holds stb and data stable until that edge.
- All outputs are registered.
- Reset (async, immediate):
  - in_ack=0, out_stb=0, out_data=0, out_id=0, busy=0, state=IDLE.
  - last pointer = N-1, so channel 0 has first priority.
  - Reset mid-transfer discards any latched word; no ack is issued afterwards.
- State IDLE:
  - Sample in_stb. Select g = first k with in_stb[k]=1, searching last+1, last+2, ... modulo N.
  - Wrap is at N, not 2**ID_W; index N-1 is followed by 0.
  - If any request is present: register g, set in_ack[g]=1 on the next edge, go to ACCEPT.
  - If none: stay in IDLE.
  - out_ack in IDLE is ignored.
- State ACCEPT:
  - in_ack[g]=1; all other in_ack bits are 0.
  - On an edge with in_stb[g]=1: latch in_data slice g into out_data, set out_id=g, out_stb=1, in_ack=0, go to OFFER. The ack pulse is therefore exactly one cycle.
  - If in_stb[g] has dropped (protocol violation): hold in_ack[g] and wait. No timeout.
  - Other channels' strobes are not observed until the next IDLE.
- State OFFER:
  - out_stb=1; out_data and out_id are held.
  - On an edge with out_ack=1: out_stb=0, last=g, go to IDLE.
  - No new word is accepted while in OFFER (single-word buffer).
- Latency and throughput:
  - in_stb rise to in_ack high: 1 cycle.
  - Accept edge to out_stb high: 1 cycle.
  - Minimum 3 cycles per word even with out_ack tied high.
- Fairness: with all N requesters continuously strobing, grants follow 0,1,...,N-1,0,...
- Simultaneous events:
  - New requests arriving during ACCEPT or OFFER are evaluated at the next IDLE against the updated last pointer.
  - A requester dropping stb while it is not granted is harmless.
- out_id zero-extends g to ID_W bits.

Test Plan:
1. Single channel: in_stb[2]=1, data 16'h1234, out_ack tied 1.
   - Required: in_ack[2] high for 1 cycle, then out_stb with out_data=16'h1234, out_id=2.
   - Required: a second word starts no earlier than 3 cycles after the first.
2. All four channels strobing constantly, data = 16'hA000+k, out_ack=1.
   - Required: out_id sequence 0,1,2,3,0,1,2,3 with matching data.
   - Required: no in_ack bit ever high for two channels at once.
3. Back-pressure: out_ack=0 for 10 cycles during OFFER.
   - Required: out_stb, out_data and out_id stable throughout; all in_ack=0.
   - Required: one transfer when out_ack rises; busy falls the following cycle.
4. Wrap and non-power-of-2: N=3, ID_W=2, last=2, requests on channels 0 and 1.
   - Required: channel 0 granted first; out_id never equals 3.
5. Reset mid-OFFER: assert rst asynchronously while out_stb=1.
   - Required: out_stb=0 and in_ack=0 immediately, without waiting for a clock edge.
   - Required: after release, channel 0 has first priority.
6. Grant stall: in_stb[1] drops after grant, before acceptance.
   - Required: in_ack[1] stays high, other channels are not granted.
   - Required: when in_stb[1] returns, its word is delivered.
